// File: rtl/usr_pkg.sv
// Shared op encoding and burst FSM state type for the universal shift register.
// No logic; constants and types only.
// No flow control; consumed by univ_shift_reg and usr_burst_ctl.
package usr_pkg;

    localparam logic [2:0] OP_HOLD    = 3'd0;
    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [2:0] OP_SHL     = 3'd2;
    localparam logic [2:0] OP_SHR     = 3'd3;
    localparam logic [2:0] OP_ROL     = 3'd4;
    localparam logic [2:0] OP_ROR     = 3'd5;
    localparam logic [2:0] OP_BURST_L = 3'd6;
    localparam logic [2:0] OP_BURST_R = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/usr_burst_ctl.sv
// Burst-shift sequencer: latches direction and clamped count, emits one shift_en per cycle.
// Latency: first shift on the start edge, done one cycle after the last shift.
// No backpressure; op is ignored while busy, clr/pre abort without done.
module usr_burst_ctl
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amt,
    output logic             shift_en,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] amt_clamp;
    logic             dir_q, dir_nxt;
    logic             busy_nxt, done_nxt;

    always_comb begin
        amt_clamp = (amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt;
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_q;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        shift_en  = 1'b0;
        dir       = dir_q;
        case (state)
            ST_IDLE: begin
                if (op == OP_BURST_L || op == OP_BURST_R) begin
                    dir_nxt = (op == OP_BURST_R);
                    dir     = dir_nxt;
                    if (amt_clamp != '0) begin
                        // First shift happens on the start edge itself.
                        shift_en = 1'b1;
                        cnt_nxt  = amt_clamp - CNT_W'(1);
                        if (cnt_nxt != '0) begin
                            state_nxt = ST_BUSY;
                            busy_nxt  = 1'b1;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt  = '0;
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                shift_en = 1'b1;
                cnt_nxt  = (cnt != '0) ? cnt - CNT_W'(1) : '0;
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr || !pre) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dir_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dir_q <= dir_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit register with load, shift, rotate and multi-cycle burst shift.
// Latency: single ops 1 cycle; burst of N shifts reports done N cycles after start.
// No backpressure; op is dropped while busy, clr beats pre beats burst beats op.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic [CNT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             busy,
    output logic             done
);

    logic             shift_en;
    logic             dir;
    logic [WIDTH-1:0] q_nxt;

    usr_burst_ctl #(.WIDTH(WIDTH)) u_burst_ctl (
        .clk      (clk),
        .clr      (clr),
        .pre      (pre),
        .op       (op),
        .amt      (amt),
        .shift_en (shift_en),
        .dir      (dir),
        .busy     (busy),
        .done     (done)
    );

    always_comb begin
        q_nxt = q;
        if (shift_en) begin
            q_nxt = dir ? {sin_msb, q[WIDTH-1:1]} : {q[WIDTH-2:0], sin_lsb};
        end else if (!busy) begin
            case (op)
                OP_LOAD: q_nxt = d;
                OP_SHL:  q_nxt = {q[WIDTH-2:0], sin_lsb};
                OP_SHR:  q_nxt = {sin_msb, q[WIDTH-1:1]};
                OP_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
                OP_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
                default: q_nxt = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            q <= '0;
        end else if (!pre) begin
            q <= '1;
        end else begin
            q <= q_nxt;
        end
    end

    assign qn     = ~q;
    assign so_msb = q[WIDTH-1];
    assign so_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8) with hand-computed expectations.
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             clr;
    logic             pre;
    logic [2:0]       op;
    logic [WIDTH-1:0] d;
    logic             sin_lsb;
    logic             sin_msb;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             so_msb;
    logic             so_lsb;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .clr     (clr),
        .pre     (pre),
        .op      (op),
        .d       (d),
        .sin_lsb (sin_lsb),
        .sin_msb (sin_msb),
        .amt     (amt),
        .q       (q),
        .qn      (qn),
        .so_msb  (so_msb),
        .so_lsb  (so_lsb),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        check8({tag, "_q"}, q, eq);
        check1({tag, "_busy"}, busy, eb);
        check1({tag, "_done"}, done, ed);
    endtask

    initial begin
        clr = 1'b0; pre = 1'b1; op = 3'd0; d = 8'h00;
        sin_lsb = 1'b0; sin_msb = 1'b0; amt = '0;
        step();
        clr = 1'b1; op = 3'd1; d = 8'hA5;
        step();
        check8("load_a5", q, 8'hA5);

        // clr and pre together: clr wins
        clr = 1'b0; pre = 1'b0; op = 3'd0;
        step();
        check_st("clr_over_pre", 8'h00, 1'b0, 1'b0);
        check8("clr_qn", qn, 8'hFF);

        clr = 1'b1; pre = 1'b1; op = 3'd1; d = 8'h81;
        step();
        check8("load_81", q, 8'h81);
        op = 3'd4;
        step();
        check8("rol", q, 8'h03);
        op = 3'd5;
        step();
        check8("ror1", q, 8'h81);
        step();
        check8("ror2", q, 8'hC0);
        check8("ror2_qn", qn, 8'h3F);
        check1("so_msb", so_msb, 1'b1);
        check1("so_lsb", so_lsb, 1'b0);
        op = 3'd2; sin_lsb = 1'b1;
        step();
        check8("shl", q, 8'h81);
        op = 3'd3; sin_msb = 1'b0;
        step();
        check8("shr", q, 8'h40);
        op = 3'd0;
        step();
        check8("hold", q, 8'h40);

        // burst left of 3 from 0x01 filling ones
        op = 3'd1; d = 8'h01;
        step();
        op = 3'd6; amt = CNT_W'(3); sin_lsb = 1'b1;
        step();
        check_st("bl3_e0", 8'h03, 1'b1, 1'b0);
        op = 3'd0;
        step();
        check_st("bl3_e1", 8'h07, 1'b1, 1'b0);
        step();
        check_st("bl3_e2", 8'h0F, 1'b0, 1'b1);
        step();
        check_st("bl3_after", 8'h0F, 1'b0, 1'b0);

        // burst right with amt clamped from 12 to 8; mid-burst LOAD dropped
        op = 3'd1; d = 8'hFF;
        step();
        op = 3'd7; amt = CNT_W'(12); sin_msb = 1'b0;
        step();
        check_st("br12_e0", 8'h7F, 1'b1, 1'b0);
        op = 3'd1; d = 8'hAA;
        step();
        check_st("br12_e1_load_ignored", 8'h3F, 1'b1, 1'b0);
        op = 3'd0;
        step(); step(); step(); step();
        check_st("br12_e5", 8'h03, 1'b1, 1'b0);
        step();
        check_st("br12_e6", 8'h01, 1'b1, 1'b0);
        step();
        check_st("br12_e7", 8'h00, 1'b0, 1'b1);

        // new burst accepted on the done cycle
        op = 3'd6; amt = CNT_W'(2); sin_lsb = 1'b1;
        step();
        check_st("bl2_e0", 8'h01, 1'b1, 1'b0);
        op = 3'd0;
        step();
        check_st("bl2_e1", 8'h03, 1'b0, 1'b1);
        step();
        check_st("bl2_after", 8'h03, 1'b0, 1'b0);

        // zero-length burst
        op = 3'd6; amt = '0;
        step();
        check_st("bl0", 8'h03, 1'b0, 1'b1);
        op = 3'd0;
        step();
        check_st("bl0_after", 8'h03, 1'b0, 1'b0);

        // single-shift burst
        op = 3'd7; amt = CNT_W'(1); sin_msb = 1'b1;
        step();
        check_st("br1", 8'h81, 1'b0, 1'b1);
        op = 3'd0;
        step();
        check_st("br1_after", 8'h81, 1'b0, 1'b0);

        // burst aborted by preset on its third cycle
        op = 3'd1; d = 8'h00;
        step();
        op = 3'd7; amt = CNT_W'(5); sin_msb = 1'b1;
        step();
        check_st("br5_e0", 8'h80, 1'b1, 1'b0);
        op = 3'd0;
        step();
        check_st("br5_e1", 8'hC0, 1'b1, 1'b0);
        pre = 1'b0;
        step();
        check_st("br5_pre", 8'hFF, 1'b0, 1'b0);
        pre = 1'b1; op = 3'd2; sin_lsb = 1'b0;
        step();
        check_st("post_pre_shl", 8'hFE, 1'b0, 1'b0);
        op = 3'd0;
        step();
        check_st("post_pre_hold", 8'hFE, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
